// File: rtl/seq_pkg.sv
// Shared definitions for the Y86 SEQ stage sequencer: instruction codes,
// processor status codes, the stage state type and the memory-op decoder.
package seq_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVL = 4'h2;
  localparam logic [3:0] ICODE_IRMOVL = 4'h3;
  localparam logic [3:0] ICODE_RMMOVL = 4'h4;
  localparam logic [3:0] ICODE_MRMOVL = 4'h5;
  localparam logic [3:0] ICODE_OPL    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHL  = 4'hA;
  localparam logic [3:0] ICODE_POPL   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_PCUPD,
    ST_HALT
  } stage_e;

  // Instructions that read or write data memory in the MEM stage.
  function automatic logic is_mem_op(input logic [3:0] code);
    logic hit;
    case (code)
      ICODE_RMMOVL, ICODE_MRMOVL, ICODE_CALL,
      ICODE_RET, ICODE_PUSHL, ICODE_POPL: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/seq_ack_timer.sv
// Memory acknowledge watchdog: counts consecutive request cycles without
// mem_ack and flags a timeout in the cycle the wait count reaches the limit.
// The counter is cleared whenever no request is active, so every new request
// starts from zero. An ack in the limit cycle suppresses the timeout.
module seq_ack_timer
  import seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req_active,
  input  logic ack,
  output logic timeout
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  // Next wait count and the timeout flag for the current request cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout    = 1'b0;
    if (!req_active || ack) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == LIMIT) begin
      timeout    = 1'b1;
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Stage sequencer for the multi-cycle Y86 SEQ core. Walks the datapath through
// FETCH/DECODE/EXEC/MEM/WB/PCUPD, arbitrates the shared memory port between
// instruction fetch and data access, and freezes in HALT on any non-AOK status.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module seq_stage_ctrl
  import seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
`ifdef SEQ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] icode,
  input  logic       instr_valid,
  input  logic       imem_error,
  input  logic       dmem_error,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       f_en,
  output logic       d_en,
  output logic       e_en,
  output logic       m_en,
  output logic       w_en,
  output logic       pc_en,
  output logic [2:0] stat
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  stage_e     state_q, state_d;
  logic [2:0] stat_q, stat_d;
  logic       mem_op;
  logic       req_active;
  logic       timeout;

  assign mem_op     = is_mem_op(icode);
  assign req_active = (state_q == ST_FETCH) || ((state_q == ST_MEM) && mem_op);
  assign mem_req    = req_active;
  assign mem_sel    = (state_q == ST_MEM) && mem_op;
  assign stat       = stat_q;

  // The watchdog only exists when a finite timeout is configured.
  generate
    if (ACK_TIMEOUT > 0) begin : g_timer
      seq_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
      ) u_timer (
        .clk       (CLK),
        .rst       (RESET),
        .req_active(req_active),
        .ack       (mem_ack),
        .timeout   (timeout)
      );
    end else begin : g_no_timer
      assign timeout = 1'b0;
    end
  endgenerate

  // Next stage, next status and the Mealy stage strobes.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    f_en    = 1'b0;
    d_en    = 1'b0;
    e_en    = 1'b0;
    m_en    = 1'b0;
    w_en    = 1'b0;
    pc_en   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack) begin
          f_en = 1'b1;
          if (imem_error) begin
            stat_d  = STAT_ADR;
            state_d = ST_HALT;
          end else if (!instr_valid) begin
            stat_d  = STAT_INS;
            state_d = ST_HALT;
          end else if (icode == ICODE_HALT) begin
            stat_d  = STAT_HLT;
            state_d = ST_HALT;
          end else begin
            state_d = ST_DECODE;
          end
        end else if (timeout) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        d_en    = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        e_en    = 1'b1;
        state_d = ST_MEM;
      end
      ST_MEM: begin
        if (!mem_op) begin
          state_d = ST_WB;
        end else if (mem_ack) begin
          m_en = 1'b1;
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = ST_HALT;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        w_en    = 1'b1;
        state_d = ST_PCUPD;
      end
      ST_PCUPD: begin
        pc_en   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage and status registers; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

  // Free-running cycle count and retired-instruction count, both wrapping.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 1'b1;
    instr_cnt_d = pc_en ? (instr_cnt_q + 1'b1) : instr_cnt_q;
  end

  // Performance counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end
`endif

endmodule
